temp_spi_reader: RTL and testbench
==================================

TEMP_SPI_READER -- requirements
Module: temp_spi_reader

Interface
REQ-001 Parameter CLK_DIV, default 25, SHALL set the SC half-period in clk cycles; legal range 2..255.
REQ-002 Parameter POLL_CYCLES, default 50_000_000, SHALL set the auto-poll interval in clk cycles; legal range 1..2^26-1.
REQ-003 clk  in  1  SHALL be the single 50 MHz clock; all state changes on its rising edge.
REQ-004 reset_n  in  1  SHALL be the asynchronous, active-low reset.
REQ-005 start  in  1  SHALL request one sensor read when high in IDLE.
REQ-006 busy  out  1  SHALL be high whenever the state is not IDLE.
REQ-007 data_valid  out  1  SHALL be a one-cycle strobe marking a new temp_data value.
REQ-008 temp_data  out  16  SHALL hold the last completed 16-bit sensor word, MSB first as received.
REQ-009 temp_cs_n  out  1  SHALL be the sensor chip select, active low.
REQ-010 temp_sc  out  1  SHALL be the serial clock, idle low.
REQ-011 temp_mosi  out  1  SHALL be the serial output, held constant 0 (read-only access).
REQ-012 temp_miso  in  1  SHALL be the sensor serial data input.

Function
REQ-013 The FSM SHALL have states IDLE, SETUP, SHIFT, HOLD and DONE, and no others.
REQ-014 IDLE->SETUP SHALL occur on the clock edge where a trigger is sampled: start=1, or a poll tick (REQ-030); temp_cs_n goes low on that edge.
REQ-015 SETUP SHALL last CLK_DIV cycles with temp_cs_n=0 and temp_sc=0, then go to SHIFT.
REQ-016 SHIFT SHALL produce exactly 16 SC periods, each CLK_DIV cycles low followed by CLK_DIV cycles high.
REQ-017 temp_miso SHALL be shifted into a 16-bit register MSB first on the last clk edge of each SC-high half-period, the same edge that drives SC low.
REQ-018 After the 16th bit, SHIFT->HOLD SHALL occur; temp_cs_n goes high and temp_sc stays low for CLK_DIV cycles.
REQ-019 HOLD->DONE SHALL occur after CLK_DIV cycles.
REQ-020 In DONE, temp_data SHALL load the shift register and data_valid SHALL be 1 for that single cycle; the next state is IDLE.
REQ-021 data_valid SHALL occur exactly 34*CLK_DIV+1 clk cycles after the edge that sampled the trigger (851 cycles at the default).
REQ-022 Triggers arriving while busy=1, including in DONE, SHALL be ignored and SHALL NOT be queued.
REQ-023 start and a poll tick on the same edge SHALL produce exactly one transaction.
REQ-024 temp_data SHALL change only in DONE and SHALL hold its value otherwise.
REQ-025 The bit counter SHALL be 5 bits wide and the divider counter 8 bits wide; neither SHALL wrap during a transaction.

Reset
REQ-026 While reset_n=0, the block SHALL force: state=IDLE, temp_cs_n=1, temp_sc=0, temp_mosi=0, busy=0, data_valid=0, temp_data=16'h0000, and all counters and the shift register to 0.
REQ-027 Reset asserted mid-transaction SHALL raise temp_cs_n without waiting for a clk edge.
REQ-028 No partial word SHALL reach temp_data after a mid-transaction reset.
REQ-029 After reset_n deasserts, the first start SHALL begin a complete 16-bit read.

Configuration
REQ-030 When macro TEMP_AUTO_POLL_EN is defined, a 26-bit counter SHALL issue a one-cycle poll tick every POLL_CYCLES clk cycles, counted from reset release.
REQ-031 With TEMP_AUTO_POLL_EN defined, the poll counter SHALL free-run while busy=1; ticks that fall while busy=1 are dropped.
REQ-032 When TEMP_AUTO_POLL_EN is undefined, no poll counter SHALL be synthesized, POLL_CYCLES SHALL be unused, and only start triggers reads.

Verification
REQ-033 Reset: hold reset_n=0 with random inputs -> temp_cs_n=1, temp_sc=0, temp_mosi=0, busy=0, data_valid=0, temp_data=16'h0000.
REQ-034 Single read: default CLK_DIV, one-cycle start pulse, sensor model returns 16'hC8A5 -> 16 SC rising edges, data_valid exactly 851 cycles after start, temp_data=16'hC8A5.
REQ-035 Busy collision: start again 100 cycles into a read -> exactly one CS-low window and one data_valid.
REQ-036 Mid-reset: reset_n pulsed low during bit 8 -> temp_cs_n=1 immediately and temp_data=0; a new start with model word 16'h0001 -> temp_data=16'h0001.
REQ-037 Auto-poll: TEMP_AUTO_POLL_EN defined, POLL_CYCLES=2000, CLK_DIV=2 -> reads start every 2000 cycles; a start coincident with a tick -> one transaction.
REQ-038 Minimum divider: CLK_DIV=2, model words 16'hFFFF then 16'h0000 -> SC period of 4 clk cycles; data_valid 69 cycles after start; both words captured exactly.

Source files
------------

// File: rtl/temp_spi_reader_if.sv
// Groups the host strobes and the sensor SPI pins of temp_spi_reader.
// The master modport is the reader; the slave modport is the host and sensor side.
interface temp_spi_reader_if;
  logic        start;
  logic        busy;
  logic        data_valid;
  logic [15:0] temp_data;
  logic        temp_cs_n;
  logic        temp_sc;
  logic        temp_mosi;
  logic        temp_miso;

  modport master (
    input  start, temp_miso,
    output busy, data_valid, temp_data, temp_cs_n, temp_sc, temp_mosi
  );

  modport slave (
    output start, temp_miso,
    input  busy, data_valid, temp_data, temp_cs_n, temp_sc, temp_mosi
  );
endinterface

// File: rtl/temp_spi_reader.sv
// SPI temperature sensor reader: one 16-bit MSB-first read per trigger, data_valid 34*CLK_DIV+1 cycles after the trigger edge.
// No backpressure: triggers are taken only in IDLE and dropped while busy; TEMP_AUTO_POLL_EN adds a periodic poll trigger.
module temp_spi_reader #(
  parameter int CLK_DIV     = 25,
  parameter int POLL_CYCLES = 50_000_000
) (
  input  logic               clk,
  input  logic               reset_n,
  temp_spi_reader_if.master  bus
);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, DONE} state_t;

  state_t      state, state_nxt;
  logic [7:0]  div_cnt;
  logic [4:0]  bit_cnt;
  logic        sc_hi;
  logic [15:0] shreg;
  logic [15:0] data_q;
  logic        div_last;
  logic        trigger;

  // Elaborates an empty marker block when a parameter is out of its legal range.
  if (CLK_DIV < 2 || CLK_DIV > 255 || POLL_CYCLES < 1 || POLL_CYCLES > 67_108_863) begin : g_illegal_params
  end

  assign div_last = (div_cnt == 8'(CLK_DIV - 1));

`ifdef TEMP_AUTO_POLL_EN
  logic [25:0] poll_cnt;
  logic        poll_tick;

  // Free-runs from reset release regardless of busy; ticks landing mid-read are lost.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)       poll_cnt <= '0;
    else if (poll_tick) poll_cnt <= '0;
    else                poll_cnt <= poll_cnt + 26'd1;
  end

  assign poll_tick = (poll_cnt == 26'(POLL_CYCLES - 1));
  assign trigger   = bus.start | poll_tick;
`else
  assign trigger   = bus.start;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (trigger) state_nxt = SETUP;
      SETUP:   if (div_last) state_nxt = SHIFT;
      SHIFT:   if (div_last && sc_hi && bit_cnt == 5'd15) state_nxt = HOLD;
      HOLD:    if (div_last) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Every phase begins with div_cnt at 0, so each lasts exactly CLK_DIV cycles.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt <= '0;
      bit_cnt <= '0;
      sc_hi   <= 1'b0;
      shreg   <= '0;
      data_q  <= '0;
    end else begin
      if (state == IDLE || state == DONE || div_last) div_cnt <= '0;
      else                                            div_cnt <= div_cnt + 8'd1;

      if (state != SHIFT) sc_hi <= 1'b0;
      else if (div_last)  sc_hi <= ~sc_hi;

      // Sample on the edge that ends the SC-high half, i.e. the SC falling edge.
      if (state == IDLE) begin
        bit_cnt <= '0;
      end else if (state == SHIFT && div_last && sc_hi) begin
        bit_cnt <= bit_cnt + 5'd1;
        shreg   <= {shreg[14:0], bus.temp_miso};
      end

      if (state == HOLD && div_last) data_q <= shreg;
    end
  end

  always_comb begin
    bus.busy       = (state != IDLE);
    bus.temp_cs_n  = !(state == SETUP || state == SHIFT);
    bus.temp_sc    = (state == SHIFT) && sc_hi;
    bus.temp_mosi  = 1'b0;
    bus.data_valid = (state == DONE);
    bus.temp_data  = data_q;
  end

endmodule

// File: tb/tb_temp_spi_reader.sv
// Directed bench for temp_spi_reader: sensor models feed known words, a scoreboard checks word and strobe cycle.
module tb_temp_spi_reader;

  logic clk = 1'b0;
  always #10 clk = ~clk;

  logic rst_a, rst_b;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;
  always @(posedge clk) cyc <= cyc + 1;

  temp_spi_reader_if ifa ();
  temp_spi_reader_if ifb ();

  temp_spi_reader #(.CLK_DIV(25)) u_a (.clk(clk), .reset_n(rst_a), .bus(ifa));
  temp_spi_reader #(.CLK_DIV(2))  u_b (.clk(clk), .reset_n(rst_b), .bus(ifb));

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endfunction

  typedef struct {
    logic [15:0] dat;
    int          at;
  } exp_t;
  exp_t q_a[$];
  exp_t q_b[$];

  // Sensor models: first bit on CS fall, next bit just after each SC fall.
  logic [15:0] word_a, word_b;
  logic        sens_a, sens_b, rnd_a, rnd_b;
  int          bit_a, bit_b;
  assign ifa.temp_miso = rst_a ? sens_a : rnd_a;
  assign ifb.temp_miso = rst_b ? sens_b : rnd_b;

  always @(negedge ifa.temp_cs_n) begin
    bit_a  = 15;
    sens_a = word_a[15];
    for (int i = 0; i < 16; i++) begin
      @(negedge ifa.temp_sc or posedge ifa.temp_cs_n);
      if (ifa.temp_cs_n) break;
      #1;
      bit_a--;
      if (bit_a >= 0) sens_a = word_a[bit_a];
    end
  end

  always @(negedge ifb.temp_cs_n) begin
    bit_b  = 15;
    sens_b = word_b[15];
    for (int i = 0; i < 16; i++) begin
      @(negedge ifb.temp_sc or posedge ifb.temp_cs_n);
      if (ifb.temp_cs_n) break;
      #1;
      bit_b--;
      if (bit_b >= 0) sens_b = word_b[bit_b];
    end
  end

  int  sc_cnt_a = 0, cs_cnt_a = 0, dv_a = 0, sc_cnt_b = 0;
  time sc_last_b = 0, sc_per_b = 0;
  always @(posedge ifa.temp_sc)   sc_cnt_a++;
  always @(negedge ifa.temp_cs_n) cs_cnt_a++;
  always @(posedge ifb.temp_sc) begin
    sc_cnt_b++;
    sc_per_b  = $time - sc_last_b;
    sc_last_b = $time;
  end

  // Monitors: a strobe seen at the negedge after edge N carries cycle stamp N.
  always @(negedge clk) begin
    if (ifa.data_valid === 1'b1) begin
      exp_t e;
      dv_a++;
      if (q_a.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL a_unexpected_dv: got strobe with %h at cycle %0d, expected none", ifa.temp_data, cyc);
      end else begin
        e = q_a.pop_front();
        check("a_temp_data", 32'(ifa.temp_data), 32'(e.dat));
        check("a_dv_cycle", cyc, e.at);
      end
    end
    if (ifb.data_valid === 1'b1) begin
      exp_t e;
      if (q_b.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL b_unexpected_dv: got strobe with %h at cycle %0d, expected none", ifb.temp_data, cyc);
      end else begin
        e = q_b.pop_front();
        check("b_temp_data", 32'(ifb.temp_data), 32'(e.dat));
        check("b_dv_cycle", cyc, e.at);
      end
    end
  end

`ifdef TEMP_AUTO_POLL_EN
  temp_spi_reader_if ifc ();
  temp_spi_reader #(.CLK_DIV(2), .POLL_CYCLES(2000)) u_c (.clk(clk), .reset_n(rst_b), .bus(ifc));
  assign ifc.temp_miso = 1'b0;
  int dvt_c[$];
  always @(negedge clk) if (ifc.data_valid === 1'b1) dvt_c.push_back(cyc);
`endif

  // Trigger is sampled on the second edge; the trigger edge's cycle stamp is returned.
  task automatic pulse_a(output int trig);
    @(posedge clk); #1 ifa.start = 1'b1;
    @(posedge clk); #1 trig = cyc; ifa.start = 1'b0;
  endtask

  task automatic pulse_b(output int trig);
    @(posedge clk); #1 ifb.start = 1'b1;
    @(posedge clk); #1 trig = cyc; ifb.start = 1'b0;
  endtask

  task automatic wait_until(input int c);
    do begin @(posedge clk); #1; end while (cyc < c);
  endtask

  initial begin
    int t, s0, c0, d0, c_rel;
    rst_a = 1'b0; rst_b = 1'b0;
    ifa.start = 1'b0; ifb.start = 1'b0;
    word_a = '0; word_b = '0; sens_a = 1'b0; sens_b = 1'b0;
    rnd_a = 1'b0; rnd_b = 1'b0;
`ifdef TEMP_AUTO_POLL_EN
    ifc.start = 1'b0;
`endif

    // Reset held with random start/miso.
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      ifa.start = 1'($urandom); ifb.start = 1'($urandom);
      rnd_a = 1'($urandom);     rnd_b = 1'($urandom);
      @(negedge clk);
      check("rst_cs_n",  32'(ifa.temp_cs_n),  32'd1);
      check("rst_sc",    32'(ifa.temp_sc),    32'd0);
      check("rst_mosi",  32'(ifa.temp_mosi),  32'd0);
      check("rst_busy",  32'(ifa.busy),       32'd0);
      check("rst_dv",    32'(ifa.data_valid), 32'd0);
      check("rst_data",  32'(ifa.temp_data),  32'h0);
      check("rst_b_cs_n", 32'(ifb.temp_cs_n), 32'd1);
      check("rst_b_busy", 32'(ifb.busy),      32'd0);
    end
    @(posedge clk); #1;
    ifa.start = 1'b0; ifb.start = 1'b0;
    rst_a = 1'b1; rst_b = 1'b1;
    c_rel = cyc;

    // Single read at CLK_DIV=25: strobe in the 851st cycle after the trigger edge.
    word_a = 16'hC8A5;
    s0 = sc_cnt_a; c0 = cs_cnt_a;
    pulse_a(t);
    q_a.push_back('{dat: 16'hC8A5, at: t + 850});
    check("a_cs_low_after_trig", 32'(ifa.temp_cs_n), 32'd0);
    check("a_busy_after_trig",   32'(ifa.busy),      32'd1);
    wait_until(t + 870);
    check("a_sc_rises", sc_cnt_a - s0, 32'd16);
    check("a_cs_windows", cs_cnt_a - c0, 32'd1);
    check("a_idle_busy", 32'(ifa.busy), 32'd0);

    // Collision: start 100 cycles in, and again during the DONE cycle.
    word_a = 16'h5A3C;
    c0 = cs_cnt_a; d0 = dv_a;
    pulse_a(t);
    q_a.push_back('{dat: 16'h5A3C, at: t + 850});
    wait_until(t + 99);
    check("a_busy_mid", 32'(ifa.busy), 32'd1);
    ifa.start = 1'b1;
    @(posedge clk); #1 ifa.start = 1'b0;
    wait_until(t + 850);
    ifa.start = 1'b1;
    @(posedge clk); #1 ifa.start = 1'b0;
    wait_until(t + 870);
    check("a_collide_cs_windows", cs_cnt_a - c0, 32'd1);
    check("a_collide_dv_count", dv_a - d0, 32'd1);
    check("a_collide_busy", 32'(ifa.busy), 32'd0);

    // Mid-transaction reset during bit 8.
    word_a = 16'h1234;
    pulse_a(t);
    wait_until(t + 17 * 25 + 10);
    check("a_hold_data", 32'(ifa.temp_data), 32'h5A3C);
    check("a_mid_cs_n_pre", 32'(ifa.temp_cs_n), 32'd0);
    rst_a = 1'b0;
    #2;
    check("a_mid_cs_n", 32'(ifa.temp_cs_n), 32'd1);
    check("a_mid_sc",   32'(ifa.temp_sc),   32'd0);
    check("a_mid_data", 32'(ifa.temp_data), 32'h0);
    check("a_mid_busy", 32'(ifa.busy),      32'd0);
    repeat (3) @(posedge clk);
    #1 rst_a = 1'b1;
    wait_until(cyc + 900);
    check("a_no_partial", 32'(ifa.temp_data), 32'h0);
    word_a = 16'h0001;
    pulse_a(t);
    q_a.push_back('{dat: 16'h0001, at: t + 850});
    wait_until(t + 870);
    check("a_after_reset_data", 32'(ifa.temp_data), 32'h0001);

    // Minimum divider: 4-cycle SC period, strobe in the 69th cycle.
    word_b = 16'hFFFF;
    s0 = sc_cnt_b;
    pulse_b(t);
    q_b.push_back('{dat: 16'hFFFF, at: t + 68});
    wait_until(t + 80);
    check("b_sc_rises", sc_cnt_b - s0, 32'd16);
    check("b_sc_period", 32'(sc_per_b), 32'd80);
    word_b = 16'h0000;
    pulse_b(t);
    q_b.push_back('{dat: 16'h0000, at: t + 68});
    wait_until(t + 80);
    check("b_last_data", 32'(ifb.temp_data), 32'h0);

`ifdef TEMP_AUTO_POLL_EN
    // Poll ticks every 2000 cycles from reset release; a coincident start adds nothing.
    check("c_first_dv", dvt_c.size() > 0 ? dvt_c[0] : -1, c_rel + 2068);
    for (int i = 1; i < dvt_c.size(); i++)
      check("c_poll_interval", dvt_c[i] - dvt_c[i-1], 32'd2000);
    if (dvt_c.size() > 0) begin
      s0 = dvt_c.size();
      t  = dvt_c[s0-1] - 68 + 2000;
      wait_until(t - 1);
      ifc.start = 1'b1;
      @(posedge clk); #1 ifc.start = 1'b0;
      wait_until(t + 100);
      check("c_coincident_count", dvt_c.size() - s0, 32'd1);
      check("c_coincident_dv", dvt_c[dvt_c.size()-1], t + 68);
    end
`endif

    check("a_queue_drained", q_a.size(), 32'd0);
    check("b_queue_drained", q_b.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
